// File: rtl/btn_repeat.sv
// Button event generator: turns a debounced level into press/release pulses,
// auto-repeat pulses after an initial delay, a repeat count and a long-hold flag.
module btn_repeat #(
    parameter int DELAY_CYC = 24,
    parameter int RATE_CYC  = 8,
    parameter int LONG_CYC  = 64,
    parameter int CNT_W     = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clean_i,
    output logic       press_o,
    output logic       rep_o,
    output logic       step_o,
    output logic       release_o,
    output logic       long_hold_o,
    output logic [3:0] rep_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_DELAY,
        S_REP,
        S_WAIT,
        S_REL
    } state_e;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYC);
    localparam logic [3:0]       REP_MAX    = 4'd15;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    // Release (clean low) is tested first in every held state so it wins over a due repeat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (clean_i) state_d = S_PRESS;
            end
            S_PRESS: begin
                if (!clean_i) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                end
            end
            S_DELAY: begin
                if (!clean_i)                state_d = S_REL;
                else if (cnt_q == DELAY_LAST) state_d = S_REP;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            S_REP: begin
                if (!clean_i) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (!clean_i)               state_d = S_REL;
                else if (cnt_q == RATE_LAST) state_d = S_REP;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Counters follow the state being entered, so the REL cycle already shows hold_cnt=0
    // and the REP cycle already shows the updated repeat count.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        if (state_d == S_IDLE || state_d == S_REL) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != LONG_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        if (state_d == S_PRESS) begin
            rep_cnt_d = '0;
        end else if (state_d == S_REP && rep_cnt_q != REP_MAX) begin
            rep_cnt_d = rep_cnt_q + 4'd1;
        end
    end

    assign press_o     = (state_q == S_PRESS);
    assign rep_o       = (state_q == S_REP);
    assign step_o      = press_o | rep_o;
    assign release_o   = (state_q == S_REL);
    assign long_hold_o = (hold_cnt_q == LONG_MAX);
    assign rep_cnt_o   = rep_cnt_q;

endmodule

// File: tb/tb_btn_repeat.sv
// Directed bench for btn_repeat with default parameters; event times are
// counted in cycles from the negedge at which clean is first driven high.
module tb_btn_repeat;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clean_i;
    logic       press_o, rep_o, step_o, release_o, long_hold_o;
    logic [3:0] rep_cnt_o;

    int checks = 0;
    int errors = 0;

    // Observations collected by watch()
    int n_press, n_rep, n_step, n_rel;
    int press_t[4];
    int rep_t[32];
    int rel_t[4];
    int lh_rise, lh_fall, lh_at_rel, rc_at_rel, rc_end;

    btn_repeat dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clean_i     (clean_i),
        .press_o     (press_o),
        .rep_o       (rep_o),
        .step_o      (step_o),
        .release_o   (release_o),
        .long_hold_o (long_hold_o),
        .rep_cnt_o   (rep_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int outs();
        return int'({press_o, rep_o, step_o, release_o, long_hold_o, rep_cnt_o});
    endfunction

    // clean is high for t<h1, low for gap cycles, high for h2 more cycles, then low.
    task automatic watch(input int h1, input int gap, input int h2);
        int total;
        bit lh_prev;
        total   = h1 + gap + h2 + 4;
        n_press = 0; n_rep = 0; n_step = 0; n_rel = 0;
        lh_rise = -1; lh_fall = -1; lh_at_rel = -1; rc_at_rel = -1; rc_end = -1;
        lh_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            press_t[i] = -1;
            rel_t[i]   = -1;
        end
        for (int i = 0; i < 32; i++) rep_t[i] = -1;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk_i);
            if (press_o) begin
                if (n_press < 4) press_t[n_press] = t;
                n_press++;
            end
            if (rep_o) begin
                if (n_rep < 32) rep_t[n_rep] = t;
                n_rep++;
            end
            if (step_o) n_step++;
            if (release_o) begin
                if (n_rel < 4) rel_t[n_rel] = t;
                n_rel++;
                lh_at_rel = int'(long_hold_o);
                rc_at_rel = int'(rep_cnt_o);
            end
            if (long_hold_o && !lh_prev && lh_rise < 0) lh_rise = t;
            if (!long_hold_o && lh_prev && lh_fall < 0) lh_fall = t;
            lh_prev = long_hold_o;
            rc_end  = int'(rep_cnt_o);
            clean_i = (t < h1) || (t >= h1 + gap && t < h1 + gap + h2);
        end
    endtask

    initial begin
        int pcount, pfirst;

        // Reset with clean already high
        rst_ni  = 1'b0;
        clean_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("rst_outs_%0d", i), outs(), 0);
        end
        rst_ni = 1'b1;
        #1;
        check("post_rst_cycle1", outs(), 0);
        pcount = 0; pfirst = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (press_o) begin
                if (pfirst < 0) pfirst = i;
                pcount++;
            end
        end
        check("post_rst_press_count", pcount, 1);
        check("post_rst_press_cycle2", pfirst, 0);
        clean_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Short tap
        watch(3, 0, 0);
        check("tap_press_n", n_press, 1);
        check("tap_press_t", press_t[0], 1);
        check("tap_rep_n", n_rep, 0);
        check("tap_rel_n", n_rel, 1);
        check("tap_rel_t", rel_t[0], 4);
        check("tap_rep_cnt", rc_end, 0);

        // Auto-repeat, 60 cycles
        watch(60, 0, 0);
        check("ar_press_t", press_t[0], 1);
        check("ar_rep_n", n_rep, 4);
        check("ar_rep0_t", rep_t[0], 26);
        check("ar_rep1_t", rep_t[1], 35);
        check("ar_rep2_t", rep_t[2], 44);
        check("ar_rep3_t", rep_t[3], 53);
        check("ar_step_n", n_step, 5);
        check("ar_rel_t", rel_t[0], 61);
        check("ar_rep_cnt_end", rc_end, 4);
        check("ar_no_long", lh_rise, -1);

        // Long hold, 100 cycles
        watch(100, 0, 0);
        check("lh_rise_t", lh_rise, 64);
        check("lh_fall_t", lh_fall, 101);
        check("lh_at_rel", lh_at_rel, 0);
        check("lh_rel_t", rel_t[0], 101);
        check("lh_rep_n", n_rep, 9);
        check("lh_rep_cnt_end", rc_end, 9);

        // 200 cycles: repeat count saturates
        watch(200, 0, 0);
        check("sat_rep_n", n_rep, 20);
        check("sat_rep19_t", rep_t[19], 197);
        check("sat_rep_cnt_rel", rc_at_rel, 15);
        check("sat_rep_cnt_end", rc_end, 15);
        check("sat_lh_fall", lh_fall, 201);

        // Clean drops on the edge where WAIT would fire the second repeat
        watch(34, 0, 0);
        check("col_rep_n", n_rep, 1);
        check("col_rel_t", rel_t[0], 35);
        check("col_rep_cnt", rc_end, 1);

        // One-cycle low during REL, then re-press
        watch(5, 1, 5);
        check("rp_press_n", n_press, 2);
        check("rp_press0_t", press_t[0], 1);
        check("rp_press1_t", press_t[1], 8);
        check("rp_rel_n", n_rel, 2);
        check("rp_rel0_t", rel_t[0], 6);
        check("rp_rel1_t", rel_t[1], 12);

        // Reset asserted in WAIT, clean still high afterwards
        @(negedge clk_i);
        clean_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check("mid_rep_cnt_before", int'(rep_cnt_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_async_outs", outs(), 0);
        @(negedge clk_i);
        check("mid_rst_held_outs", outs(), 0);
        rst_ni = 1'b1;
        #1;
        check("mid_post_rst_cycle1", outs(), 0);
        @(negedge clk_i);
        check("mid_repress", int'(press_o), 1);
        @(negedge clk_i);
        check("mid_repress_single", int'(press_o), 0);
        clean_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("final_idle_outs", outs() & 32'h1F0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_repeat.md
Name: btn_repeat

Overview:
- Consumes the debounced `clean` level produced by the button debouncer.
- Turns it into discrete input events for game logic:
  - one-cycle press and release pulses
  - auto-repeat pulses while the button is held (ship movement, menu scroll)
  - a long-hold flag
- One instance per button, placed between the debouncer and the game controller FSM.

Parameters:
- DELAY_CYC, 24, cycles spent in DELAY before the first repeat pulse; legal range 1..2^CNT_W.
- RATE_CYC, 8, cycles spent in WAIT between successive repeat pulses; legal range 1..2^CNT_W.
- LONG_CYC, 64, held cycles before `long_hold` asserts; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the internal interval counter and hold counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- clean  input  1  debounced button level, synchronous to clk.
- press  output  1  one-cycle pulse, first cycle of a press.
- rep  output  1  one-cycle auto-repeat pulse.
- step  output  1  press | rep; one-cycle pulse for each action.
- release  output  1  one-cycle pulse when the button is released.
- long_hold  output  1  level; high while held at least LONG_CYC cycles.
- rep_cnt  output  4  number of repeats in the current/last hold; saturates at 15.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, interval counter=0, hold_cnt=0, rep_cnt=0.
  - All outputs 0 during reset and in the first cycle after release of reset.
- Outputs are Moore-decoded from state (press=PRESS, rep=REP, release=REL). No combinational path from `clean` to any output.
- States and transitions (evaluated each posedge):
  - IDLE: clean=1 -> PRESS; else stay.
  - PRESS (1 cycle): clean=0 -> REL; else -> DELAY with cnt=0. rep_cnt cleared to 0 here.
  - DELAY: clean=0 -> REL. Else if cnt==DELAY_CYC-1 -> REP. Else cnt++.
  - REP (1 cycle): rep_cnt++ (saturating at 15). Then clean=0 -> REL; else -> WAIT with cnt=0.
  - WAIT: clean=0 -> REL. Else if cnt==RATE_CYC-1 -> REP. Else cnt++.
  - REL (1 cycle): always -> IDLE, even if clean=1. A re-press is seen from IDLE one cycle later.
- Latency and timing:
  - clean rising, sampled at edge k -> press high in cycle k+1.
  - The first rep occurs DELAY_CYC+1 cycles after the press cycle.
  - Subsequent reps occur every RATE_CYC+1 cycles.
  - With defaults: first repeat 25 cycles after press, then every 9 cycles.
- Release:
  - clean falling, sampled in any held state -> release high the next cycle.
  - Release takes priority over a repeat that would have fired on the same edge.
- hold_cnt and long_hold:
  - hold_cnt increments in PRESS/DELAY/REP/WAIT, saturating at LONG_CYC.
  - hold_cnt clears to 0 in IDLE and REL.
  - long_hold = (hold_cnt==LONG_CYC); it drops to 0 in the REL cycle.
- rep_cnt holds its value through REL/IDLE until the next PRESS, so the game FSM can read it after release.
- Boundaries and edge cases:
  - DELAY_CYC=1 or RATE_CYC=1 gives one DELAY/WAIT cycle (no zero-length interval).
  - cnt never exceeds DELAY_CYC-1 or RATE_CYC-1, so there is no wrap-around.
  - Reset asserted mid-hold returns to IDLE immediately.
  - After reset, a still-high clean produces a fresh press (cycle 2 after deassertion).

Test Plan:
- Reset: hold rst=0 for 5 cycles with clean=1 -> all outputs 0; after rst=1, press pulses exactly once in cycle 2 after deassertion.
- Short tap: clean high for 3 cycles -> press=1 once; no rep; release=1 exactly one cycle after clean is sampled low; rep_cnt=0.
- Auto-repeat (defaults): clean high 60 cycles -> press at cycle P; rep at P+25, P+34, P+43, P+52; step pulses 5 times; rep_cnt=4 after release.
- Long hold (defaults):
  - Clean high 100 cycles -> long_hold rises when hold_cnt reaches 64 and stays high until the REL cycle, where it drops to 0.
  - Over 200 cycles, rep_cnt stops at 15 and does not wrap.
- Release/repeat collision: drop clean on the edge where WAIT cnt==7 -> release=1 next cycle, rep stays 0, rep_cnt unchanged.
- Mid-hold reset and re-press:
  - Assert rst=0 during WAIT -> outputs clear asynchronously.
  - Release clean 1 cycle in the REL state, then re-raise -> press fires from IDLE; no missed or double press.
